channel_decorrelator: RTL and testbench

CHANNEL_DECORRELATOR -- requirements
Module: channel_decorrelator

---
 rtl/channel_decorrelator_if.sv | 25 ++
 rtl/channel_decorrelator.sv | 224 ++++++++++++++++++++++
 tb/tb_channel_decorrelator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/channel_decorrelator_if.sv
// Sample/handshake bus between the subframe decoder side and the channel decorrelator.
// The master drives frame control and samples; the slave returns reconstructed L/R.
interface channel_decorrelator_if;
    logic               iStart;
    logic [3:0]         iChannelAssign;
    logic [15:0]        iBlockSize;
    logic               iSampleValid;
    logic signed [16:0] iSample;
    logic signed [15:0] oLeft;
    logic signed [15:0] oRight;
    logic               oValid;
    logic               oFrameDone;
    logic               oBusy;
    logic               oError;

    modport master (
        output iStart, iChannelAssign, iBlockSize, iSampleValid, iSample,
        input  oLeft, oRight, oValid, oFrameDone, oBusy, oError
    );

    modport slave (
        input  iStart, iChannelAssign, iBlockSize, iSampleValid, iSample,
        output oLeft, oRight, oValid, oFrameDone, oBusy, oError
    );
endinterface

// File: rtl/channel_decorrelator.sv
// FLAC inter-channel decorrelator: buffers channel 0 of a stereo frame, then pairs it
// with channel 1 on the fly to rebuild left/right; mono frames pass straight through.
module channel_decorrelator #(
    parameter int unsigned BUF_DEPTH = 4096,
    parameter int unsigned ABITS     = 12
) (
    input  logic                  iClock,
    input  logic                  iReset,
    channel_decorrelator_if.slave bus
);
    localparam int unsigned SW = 17;   // decoded sample width
    localparam int unsigned AW = 18;   // arithmetic intermediate width
    localparam int unsigned OW = 16;   // output sample width
    localparam int unsigned BW = 16;   // block size / counter width
    localparam int unsigned LW = BW + 1;
    localparam logic [LW-1:0] DEPTH_LIMIT = LW'(BUF_DEPTH);

    localparam logic [3:0] CODE_MONO  = 4'd0;
    localparam logic [3:0] CODE_INDEP = 4'd1;
    localparam logic [3:0] CODE_LS    = 4'd8;
    localparam logic [3:0] CODE_RS    = 4'd9;
    localparam logic [3:0] CODE_MS    = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CH0  = 2'd1,
        S_CH1  = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           code_q, code_d;
    logic [BW-1:0]        blk_q, blk_d;
    logic [BW-1:0]        cnt_q, cnt_d;
    logic signed [OW-1:0] left_q, left_d;
    logic signed [OW-1:0] right_q, right_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic signed [SW-1:0] mem [BUF_DEPTH];
    logic signed [SW-1:0] rd_data_q;
    logic                 wr_en_c;
    logic [ABITS-1:0]     wr_addr_c;
    logic                 rd_en_c;
    logic [ABITS-1:0]     rd_addr_c;

    logic                 code_ok_c;
    logic                 start_bad_c;
    logic                 last_c;
    logic signed [AW-1:0] a_c, b_c, m_c, sum_c, dif_c;
    logic signed [AW-1:0] full_l_c, full_r_c;

    // Frame parameter validation at iStart time
    always_comb begin
        code_ok_c   = (bus.iChannelAssign == CODE_MONO) || (bus.iChannelAssign == CODE_INDEP) ||
                      (bus.iChannelAssign == CODE_LS)   || (bus.iChannelAssign == CODE_RS)    ||
                      (bus.iChannelAssign == CODE_MS);
        start_bad_c = !code_ok_c || (bus.iBlockSize == '0) ||
                      ({1'b0, bus.iBlockSize} > DEPTH_LIMIT);
    end

    // Stereo reconstruction: a = buffered channel 0, b = incoming channel 1
    always_comb begin
        a_c   = {rd_data_q[SW-1], rd_data_q};
        b_c   = {bus.iSample[SW-1], bus.iSample};
        m_c   = (a_c <<< 1) | AW'(b_c[0]);
        sum_c = m_c + b_c;
        dif_c = m_c - b_c;
        case (code_q)
            CODE_LS: begin
                full_l_c = a_c;
                full_r_c = a_c - b_c;
            end
            CODE_RS: begin
                full_l_c = a_c + b_c;
                full_r_c = b_c;
            end
            CODE_MS: begin
                full_l_c = sum_c >>> 1;
                full_r_c = dif_c >>> 1;
            end
            default: begin
                full_l_c = a_c;
                full_r_c = b_c;
            end
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        blk_d     = blk_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy_q;
        err_d     = err_q;
        wr_en_c   = 1'b0;
        wr_addr_c = ABITS'(cnt_q);
        rd_en_c   = 1'b0;
        rd_addr_c = '0;
        last_c    = (cnt_q == (blk_q - BW'(1)));

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                // A start landing on the final-output cycle of a frame is dropped.
                if (bus.iStart && !done_q) begin
                    if (start_bad_c) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        code_d  = bus.iChannelAssign;
                        blk_d   = bus.iBlockSize;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_CH0;
                    end
                end
            end

            S_CH0: begin
                if (bus.iSampleValid) begin
                    cnt_d = cnt_q + BW'(1);
                    if (code_q == CODE_MONO) begin
                        left_d  = OW'(bus.iSample);
                        right_d = OW'(bus.iSample);
                        valid_d = 1'b1;
                        if (last_c) begin
                            done_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        wr_en_c = 1'b1;
                        if (last_c) begin
                            // Prefetch word 0 so the first channel-1 sample finds it ready.
                            cnt_d     = '0;
                            rd_en_c   = 1'b1;
                            rd_addr_c = '0;
                            state_d   = S_CH1;
                        end
                    end
                end
            end

            S_CH1: begin
                if (bus.iSampleValid) begin
                    left_d  = OW'(full_l_c);
                    right_d = OW'(full_r_c);
                    valid_d = 1'b1;
                    if (last_c) begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d     = cnt_q + BW'(1);
                        rd_en_c   = 1'b1;
                        rd_addr_c = ABITS'(cnt_q + BW'(1));
                    end
                end
            end

            S_ERR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            blk_q   <= '0;
            cnt_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Channel-0 buffer; a same-address write forwards to the read (block size 1).
    always_ff @(posedge iClock) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= bus.iSample;
        end
        if (rd_en_c) begin
            rd_data_q <= (wr_en_c && (wr_addr_c == rd_addr_c)) ? bus.iSample : mem[rd_addr_c];
        end
    end

    assign bus.oLeft      = left_q;
    assign bus.oRight     = right_q;
    assign bus.oValid     = valid_q;
    assign bus.oFrameDone = done_q;
    assign bus.oBusy      = busy_q;
    assign bus.oError     = err_q;

endmodule

// File: tb/tb_channel_decorrelator.sv
// Directed bench for channel_decorrelator: hand-computed L/R vectors per channel mode,
// latency, frame-done timing, error handling and reset/start collisions.
module tb_channel_decorrelator;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    channel_decorrelator_if bus ();

    channel_decorrelator #(
        .BUF_DEPTH(4096),
        .ABITS    (12)
    ) dut (
        .iClock(clk),
        .iReset(rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int out_l[$];
    int out_r[$];
    int out_d[$];
    int out_b[$];
    int out_c[$];
    int prod_c[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output beat together with the cycle it appeared in
    always @(negedge clk) begin
        if (bus.oValid === 1'b1) begin
            out_l.push_back(int'(bus.oLeft));
            out_r.push_back(int'(bus.oRight));
            out_d.push_back(int'(bus.oFrameDone));
            out_b.push_back(int'(bus.oBusy));
            out_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int s, input bit prod);
        bus.iSampleValid = 1'b1;
        bus.iSample      = 17'(s);
        if (prod) prod_c.push_back(cyc);
        tick();
        bus.iSampleValid = 1'b0;
        bus.iSample      = '0;
    endtask

    task automatic start(input logic [3:0] code, input int blk);
        bus.iStart         = 1'b1;
        bus.iChannelAssign = code;
        bus.iBlockSize     = 16'(blk);
        tick();
        bus.iStart = 1'b0;
    endtask

    task automatic clear_q();
        out_l.delete();
        out_r.delete();
        out_d.delete();
        out_b.delete();
        out_c.delete();
        prod_c.delete();
    endtask

    task automatic check_frame(input string tag, input int n, input int el[4], input int er[4]);
        int budget = 20;
        while (out_l.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        idle(2);
        chk({tag, ".count"}, out_l.size(), n);
        for (int i = 0; i < n && i < int'(out_l.size()); i++) begin
            chk($sformatf("%s.L%0d", tag, i), out_l[i], el[i]);
            chk($sformatf("%s.R%0d", tag, i), out_r[i], er[i]);
            chk($sformatf("%s.done%0d", tag, i), out_d[i], (i == n - 1) ? 1 : 0);
            chk($sformatf("%s.busy%0d", tag, i), out_b[i], 1);
            if (i < int'(prod_c.size()))
                chk($sformatf("%s.lat%0d", tag, i), out_c[i] - prod_c[i], 1);
        end
        clear_q();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst                = 1'b1;
        bus.iStart         = 1'b0;
        bus.iChannelAssign = '0;
        bus.iBlockSize     = '0;
        bus.iSampleValid   = 1'b0;
        bus.iSample        = '0;
        idle(3);
        chk("rst.valid", bus.oValid, 0);
        chk("rst.done", bus.oFrameDone, 0);
        chk("rst.busy", bus.oBusy, 0);
        chk("rst.err", bus.oError, 0);
        chk("rst.L", bus.oLeft, 0);
        chk("rst.R", bus.oRight, 0);
        rst = 1'b0;
        idle(2);

        // Left/side, block 4, back to back
        start(4'd8, 4);
        chk("A.busy", bus.oBusy, 1);
        chk("A.err", bus.oError, 0);
        send(100, 0); send(-5, 0); send(0, 0); send(32767, 0);
        send(10, 1);  send(-5, 1); send(1, 1); send(-1, 1);
        check_frame("A", 4, '{100, -5, 0, 32767}, '{90, 0, -1, -32768});
        chk("A.busy_after", bus.oBusy, 0);

        // Mid/side, block 2, with a gap inside channel 1
        start(4'd10, 2);
        send(3, 0); send(-2, 0);
        send(1, 1);
        tick();
        chk("B.hold_valid", bus.oValid, 0);
        chk("B.hold_L", bus.oLeft, 4);
        chk("B.hold_R", bus.oRight, 3);
        send(-3, 1);
        check_frame("B", 2, '{4, -3, 0, 0}, '{3, 0, 0, 0});

        // Side/right, block 1: full 17-bit side value
        start(4'd9, 1);
        send(65535, 0);
        send(-32768, 1);
        check_frame("C", 1, '{32767, 0, 0, 0}, '{-32768, 0, 0, 0});

        // Mono, block 3, then start collisions around the final output
        start(4'd0, 3);
        send(1, 1); send(2, 1); send(3, 1);
        start(4'd1, 2);
        chk("D.start_on_done_ignored", bus.oBusy, 0);
        start(4'd1, 2);
        chk("D.start_next_cycle_taken", bus.oBusy, 1);
        check_frame("D", 3, '{1, 2, 3, 0}, '{1, 2, 3, 0});

        // Independent, block 2 (frame opened above)
        send(7, 0); send(8, 0);
        send(9, 1); send(10, 1);
        check_frame("E", 2, '{7, 8, 0, 0}, '{9, 10, 0, 0});

        // Error handling
        start(4'd12, 4);
        chk("F.code12_err", bus.oError, 1);
        chk("F.code12_busy", bus.oBusy, 0);
        send(1, 0); send(2, 0); send(3, 0);
        idle(2);
        chk("F.code12_no_valid", out_l.size(), 0);
        clear_q();
        start(4'd0, 1);
        chk("F.clear_err", bus.oError, 0);
        chk("F.clear_busy", bus.oBusy, 1);
        send(-9, 1);
        check_frame("F1", 1, '{-9, 0, 0, 0}, '{-9, 0, 0, 0});
        start(4'd1, 4097);
        chk("F.blk4097_err", bus.oError, 1);
        chk("F.blk4097_busy", bus.oBusy, 0);
        idle(1);
        start(4'd0, 1);
        chk("F.clear_err2", bus.oError, 0);
        send(5, 1);
        check_frame("F2", 1, '{5, 0, 0, 0}, '{5, 0, 0, 0});
        start(4'd1, 0);
        chk("F.blk0_err", bus.oError, 1);
        idle(1);
        start(4'd1, 4096);
        chk("F.blk4096_err", bus.oError, 0);
        chk("F.blk4096_busy", bus.oBusy, 1);
        rst = 1'b1;
        #2;
        chk("F.rst_busy", bus.oBusy, 0);
        tick();
        rst = 1'b0;
        tick();

        // Reset mid-frame, then a clean frame with an ignored start in channel 1
        start(4'd8, 4);
        send(11, 0); send(22, 0);
        rst = 1'b1;
        #2;
        chk("G.rst_busy", bus.oBusy, 0);
        chk("G.rst_L", bus.oLeft, 0);
        chk("G.rst_R", bus.oRight, 0);
        tick();
        rst = 1'b0;
        tick();
        start(4'd1, 2);
        send(5, 0); send(6, 0);
        send(-7, 1);
        start(4'd0, 1);
        chk("G.start_in_ch1_busy", bus.oBusy, 1);
        send(-8, 1);
        check_frame("G", 2, '{5, 6, 0, 0}, '{-7, -8, 0, 0});
        chk("G.busy_after", bus.oBusy, 0);
        chk("G.err_after", bus.oError, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
